// File: rtl/pwm_pkg.sv
// Shared PWM definitions: dead-time FSM state encoding and the default count width.
package pwm_pkg;

  localparam int DT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    HI_ON,
    LO_ON,
    DEAD_TO_HI,
    DEAD_TO_LO
  } pwm_dt_state_t;

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter timing the dead band; holds at zero rather than wrapping.
module pwm_dt_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with programmable dead band around every edge.
// Define PWM_DT_FAULT_EN to add a latched fault input that forces both outputs off.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = pwm_pkg::DT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [DT_W-1:0] dead_time,
  input  logic            pwm_in,
  output logic            pwm_hi,
  output logic            pwm_lo,
  output logic            dead_active
`ifdef PWM_DT_FAULT_EN
  ,
  input  logic            fault,
  input  logic            fault_clr,
  output logic            fault_latched
`endif
);

  pwm_dt_state_t state_q, state_d;
  logic          pwm_hi_q, pwm_hi_d;
  logic          pwm_lo_q, pwm_lo_d;
  logic          dead_q, dead_d;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [DT_W-1:0] cnt_value;
  logic          force_idle;

`ifdef PWM_DT_FAULT_EN
  logic fault_latched_q, fault_latched_d;

  always_comb begin
    fault_latched_d = fault_latched_q;
    if (fault) begin
      fault_latched_d = 1'b1;
    end else if (fault_clr) begin
      fault_latched_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_latched_q <= 1'b0;
    end else begin
      fault_latched_q <= fault_latched_d;
    end
  end

  assign force_idle    = !en || fault || fault_latched_q;
  assign fault_latched = fault_latched_q;
`else
  assign force_idle = !en;
`endif

  pwm_dt_counter #(.W(DT_W)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (dead_time),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (force_idle) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = pwm_in ? HI_ON : LO_ON;
        HI_ON: begin
          if (!pwm_in) begin
            state_d  = DEAD_TO_LO;
            cnt_load = 1'b1;
          end
        end
        LO_ON: begin
          if (pwm_in) begin
            state_d  = DEAD_TO_HI;
            cnt_load = 1'b1;
          end
        end
        // An input that reverts mid-band returns to the side that never switched off-to-on.
        DEAD_TO_LO: begin
          if (cnt_zero && !pwm_in) begin
            state_d = LO_ON;
          end else if (pwm_in) begin
            state_d = HI_ON;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        DEAD_TO_HI: begin
          if (cnt_zero && pwm_in) begin
            state_d = HI_ON;
          end else if (!pwm_in) begin
            state_d = LO_ON;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pwm_hi_d = (state_d == HI_ON);
    pwm_lo_d = (state_d == LO_ON);
    dead_d   = (state_d == DEAD_TO_HI) || (state_d == DEAD_TO_LO);
  end

  // Outputs are flopped from the next-state decode so they stay glitch-free and
  // line up exactly with the registered state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pwm_hi_q <= 1'b0;
      pwm_lo_q <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwm_hi_q <= pwm_hi_d;
      pwm_lo_q <= pwm_lo_d;
      dead_q   <= dead_d;
    end
  end

  assign pwm_hi      = pwm_hi_q;
  assign pwm_lo      = pwm_lo_q;
  assign dead_active = dead_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: stimulus queues expected outputs, a monitor compares them.
module tb_pwm_deadtime;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] dead_time;
  logic       pwm_in;
  logic       pwm_hi;
  logic       pwm_lo;
  logic       dead_active;
  logic       fault;
  logic       fault_clr;
  logic       flt;

  int checks;
  int errors;

  logic [3:0] exp_q[$];
  string      name_q[$];
  event       sample_ev;

  pwm_deadtime #(.DT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .dead_time   (dead_time),
    .pwm_in      (pwm_in),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .dead_active (dead_active)
`ifdef PWM_DT_FAULT_EN
    ,
    .fault       (fault),
    .fault_clr   (fault_clr),
    .fault_latched (flt)
`endif
  );

`ifndef PWM_DT_FAULT_EN
  assign flt = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One registered-output expectation per clock edge: {hi, lo, dead, fault_latched}.
  task automatic step(input logic e, input logic p, input logic [7:0] dt,
                      input logic eh, input logic el, input logic ed, input logic ef,
                      input string nm);
    en        = e;
    pwm_in    = p;
    dead_time = dt;
    @(posedge clk);
    exp_q.push_back({eh, el, ed, ef});
    name_q.push_back(nm);
    #2;
  endtask

  // Raise reset between edges and check that outputs drop without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    exp_q.push_back(4'b0000);
    name_q.push_back("rst_async");
    ->sample_ev;
    #1;
  endtask

  initial begin : monitor
    logic [3:0] e;
    logic [3:0] act;
    string      nm;
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {pwm_hi, pwm_lo, dead_active, flt};
        checks++;
        if (act !== e || (pwm_hi && pwm_lo)) begin
          errors++;
          $display("FAIL %s hi/lo/dead/flt got %b need %b", nm, act, e);
        end else begin
          $display("ok   %s hi/lo/dead/flt %b", nm, act);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    en        = 1'b0;
    pwm_in    = 1'b0;
    dead_time = 8'd3;
    fault     = 1'b0;
    fault_clr = 1'b0;

    // Reset held, then released with en low: outputs stay off while pwm_in toggles.
    step(0, 1, 3, 0, 0, 0, 0, "rst_hold");
    step(0, 0, 3, 0, 0, 0, 0, "rst_hold");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(0, i[0], 3, 0, 0, 0, 0, "en_off");

    // Enable from IDLE goes straight to the low side with no dead band.
    step(1, 0, 3, 0, 1, 0, 0, "idle_to_lo");

    // dead_time=3: every edge gives 4 dead cycles. In the second period dead_time is
    // changed inside each band, which must not stretch it.
    for (int per = 0; per < 2; per++) begin
      for (int i = 0; i < 10; i++)
        step(1, 1, (per == 1 && i > 0) ? 8'd9 : 8'd3, (i >= 4), 0, (i < 4), 0, "ins_hi");
      for (int i = 0; i < 10; i++)
        step(1, 0, (per == 1 && i > 0) ? 8'd9 : 8'd3, 0, (i >= 4), (i < 4), 0, "ins_lo");
    end

    // dead_time=0: single-cycle gap on both edges.
    step(1, 1, 0, 0, 0, 1, 0, "mg_dead_hi");
    step(1, 1, 0, 1, 0, 0, 0, "mg_hi_rise");
    step(1, 1, 0, 1, 0, 0, 0, "mg_hi");
    step(1, 0, 0, 0, 0, 1, 0, "mg_hi_drop");
    step(1, 0, 0, 0, 1, 0, 0, "mg_lo_rise");

    // Short high pulse shorter than a 6-cycle band: aborts back to LO_ON.
    step(1, 1, 5, 0, 0, 1, 0, "sp_dead");
    step(1, 1, 5, 0, 0, 1, 0, "sp_dead");
    step(1, 0, 5, 0, 1, 0, 0, "sp_abort_lo");
    step(1, 0, 5, 0, 1, 0, 0, "sp_lo");

    // dead_time=7: drop en with the counter at 4, then re-enable high.
    for (int i = 0; i < 4; i++) step(1, 1, 7, 0, 0, 1, 0, "en_band");
    step(0, 1, 7, 0, 0, 0, 0, "en_drop");
    step(1, 1, 7, 1, 0, 0, 0, "reen_hi");

    // Short low pulse from HI_ON aborts back to HI_ON.
    step(1, 0, 5, 0, 0, 1, 0, "sp2_dead");
    step(1, 0, 5, 0, 0, 1, 0, "sp2_dead");
    step(1, 1, 5, 1, 0, 0, 0, "sp2_abort_hi");
    step(1, 1, 5, 1, 0, 0, 0, "sp2_hi");

    // Asynchronous reset in the middle of a band.
    for (int i = 0; i < 3; i++) step(1, 0, 7, 0, 0, 1, 0, "rst_band");
    async_reset();
    step(1, 1, 7, 0, 0, 0, 0, "rst_held");
    reset = 1'b0;
    step(1, 1, 7, 1, 0, 0, 0, "post_rst_hi");

`ifdef PWM_DT_FAULT_EN
    fault = 1'b1;
    step(1, 1, 7, 0, 0, 0, 1, "flt_set");
    fault = 1'b0;
    step(1, 1, 7, 0, 0, 0, 1, "flt_hold");
    fault     = 1'b1;
    fault_clr = 1'b1;
    step(1, 1, 7, 0, 0, 0, 1, "flt_clr_blocked");
    fault = 1'b0;
    step(1, 1, 7, 0, 0, 0, 0, "flt_clr");
    fault_clr = 1'b0;
    step(1, 1, 7, 1, 0, 0, 0, "flt_resume");
`endif

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
